// File: rtl/hilo_mdu_pkg.sv
// hilo_mdu_pkg: op encodings, FSM states and op-decode helpers for the HI/LO multiply/divide unit.
// Revision: 1.0
`default_nettype none

package hilo_mdu_pkg;

  localparam logic [2:0] MDU_MULT_OP  = 3'd0;
  localparam logic [2:0] MDU_MULTU_OP = 3'd1;
  localparam logic [2:0] MDU_DIV_OP   = 3'd2;
  localparam logic [2:0] MDU_DIVU_OP  = 3'd3;
  localparam logic [2:0] MDU_MADD_OP  = 3'd4;
  localparam logic [2:0] MDU_MADDU_OP = 3'd5;
  localparam logic [2:0] MDU_MSUB_OP  = 3'd6;
  localparam logic [2:0] MDU_MSUBU_OP = 3'd7;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_MUL  = 3'd1,
    ST_ACC  = 3'd2,
    ST_DIV  = 3'd3,
    ST_DONE = 3'd4
  } mdu_state_e;

  // Encoding puts the unsigned flavour on bit 0, accumulate on bit 2, subtract on bit 1 of accumulate ops.
  function automatic logic op_is_signed(input logic [2:0] op);
    return ~op[0];
  endfunction

  function automatic logic op_is_div(input logic [2:0] op);
    return (op[2:1] == 2'b01);
  endfunction

  function automatic logic op_is_acc(input logic [2:0] op);
    return op[2];
  endfunction

  function automatic logic op_is_sub(input logic [2:0] op);
    return op[2] & op[1];
  endfunction

endpackage

`default_nettype wire

// File: rtl/hilo_mdu_div_iter.sv
// mdu_div_iter: restoring-division step datapath, one quotient bit per step on unsigned magnitudes.
// Revision: 1.0
`default_nettype none

module mdu_div_iter #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_i,
  input  logic              step_i,
  input  logic [DATA_W-1:0] dividend_i,
  input  logic [DATA_W-1:0] divisor_i,
  output logic [DATA_W-1:0] quot_next_o,
  output logic [DATA_W-1:0] rem_next_o,
  output logic              last_o
);

  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  logic [DATA_W-1:0] rem_q;
  logic [DATA_W-1:0] quot_q;
  logic [DATA_W-1:0] dvsr_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [DATA_W:0]   partial;
  logic              fits;

  // Remainder stays below the divisor, so the shifted partial needs one extra bit; the
  // low DATA_W bits of the difference are exact whenever the subtraction is taken.
  assign partial     = {rem_q, quot_q[DATA_W-1]};
  assign fits        = (partial >= {1'b0, dvsr_q});
  assign rem_next_o  = fits ? (partial[DATA_W-1:0] - dvsr_q) : partial[DATA_W-1:0];
  assign quot_next_o = {quot_q[DATA_W-2:0], fits};
  assign last_o      = (cnt_q == CNT_W'(DATA_W - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_q  <= '0;
      quot_q <= '0;
      dvsr_q <= '0;
      cnt_q  <= '0;
    end else if (load_i) begin
      rem_q  <= '0;
      quot_q <= dividend_i;
      dvsr_q <= divisor_i;
      cnt_q  <= '0;
    end else if (step_i) begin
      rem_q  <= rem_next_o;
      quot_q <= quot_next_o;
      cnt_q  <= cnt_q + CNT_W'(1);
    end
  end

endmodule

`default_nettype wire

// File: rtl/hilo_mdu.sv
// hilo_mdu: iterative MULT/DIV/MADD/MSUB unit for the HI/LO path with start/ready handshake and annul.
// Revision: 1.0
`default_nettype none

module hilo_mdu
  import hilo_mdu_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int MUL_BITS = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_i,
  input  logic [2:0]            op_i,
  input  logic [DATA_W-1:0]     opdata1_i,
  input  logic [DATA_W-1:0]     opdata2_i,
  input  logic [2*DATA_W-1:0]   hilo_i,
  input  logic                  annul_i,
  output logic                  busy_o,
  output logic                  ready_o,
  output logic [2*DATA_W-1:0]   result_o,
  output logic                  div_zero_o
);

  localparam int N     = DATA_W / MUL_BITS;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

  mdu_state_e           state_q;
  logic [2:0]           op_q;
  logic [2*DATA_W-1:0]  mcand_q;
  logic [DATA_W-1:0]    mplier_q;
  logic [2*DATA_W-1:0]  prod_q;
  logic [2*DATA_W-1:0]  hilo_q;
  logic                 neg_q;
  logic                 rem_neg_q;
  logic [CNT_W-1:0]     cnt_q;
  logic                 busy_q;
  logic                 ready_q;
  logic                 dz_q;
  logic [2*DATA_W-1:0]  result_q;

  logic                 accept;
  logic                 sgn_op;
  logic [DATA_W-1:0]    a_mag;
  logic [DATA_W-1:0]    b_mag;
  logic [2*DATA_W-1:0]  pp;
  logic [2*DATA_W-1:0]  prod_d;
  logic [2*DATA_W-1:0]  mul_res;
  logic [2*DATA_W-1:0]  acc_src;
  logic [2*DATA_W-1:0]  acc_d;
  logic [DATA_W-1:0]    quot_next;
  logic [DATA_W-1:0]    rem_next;
  logic [DATA_W-1:0]    quot_fix;
  logic [DATA_W-1:0]    rem_fix;
  logic                 div_last;
  logic                 div_load;
  logic                 div_step;

  assign accept = start_i & ~busy_q & ~annul_i;
  assign sgn_op = op_is_signed(op_i);
  assign a_mag  = (sgn_op && opdata1_i[DATA_W-1]) ? -opdata1_i : opdata1_i;
  assign b_mag  = (sgn_op && opdata2_i[DATA_W-1]) ? -opdata2_i : opdata2_i;

  always_comb begin
    pp = '0;
    for (int j = 0; j < MUL_BITS; j++) begin
      if (mplier_q[j]) pp = pp + (mcand_q << j);
    end
    prod_d = prod_q + pp;
  end

  assign mul_res = neg_q ? -prod_d : prod_d;
  assign acc_src = neg_q ? -prod_q : prod_q;
  assign acc_d   = op_is_sub(op_q) ? (hilo_q - acc_src) : (hilo_q + acc_src);

  assign div_load = accept & op_is_div(op_i) & (opdata2_i != '0);
  assign div_step = (state_q == ST_DIV);
  assign quot_fix = neg_q ? -quot_next : quot_next;
  assign rem_fix  = rem_neg_q ? -rem_next : rem_next;

  mdu_div_iter #(
    .DATA_W(DATA_W)
  ) u_div (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (div_load),
    .step_i     (div_step),
    .dividend_i (a_mag),
    .divisor_i  (b_mag),
    .quot_next_o(quot_next),
    .rem_next_o (rem_next),
    .last_o     (div_last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      op_q      <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      prod_q    <= '0;
      hilo_q    <= '0;
      neg_q     <= 1'b0;
      rem_neg_q <= 1'b0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      ready_q   <= 1'b0;
      dz_q      <= 1'b0;
      result_q  <= '0;
    end else begin
      ready_q <= 1'b0;
      if (annul_i && busy_q) begin
        state_q <= ST_IDLE;
        busy_q  <= 1'b0;
      end else begin
        case (state_q)
          ST_IDLE, ST_DONE: begin
            state_q <= ST_IDLE;
            if (accept) begin
              op_q      <= op_i;
              hilo_q    <= hilo_i;
              neg_q     <= sgn_op & (opdata1_i[DATA_W-1] ^ opdata2_i[DATA_W-1]);
              rem_neg_q <= sgn_op & opdata1_i[DATA_W-1];
              dz_q      <= 1'b0;
              if (op_is_div(op_i)) begin
                if (opdata2_i == '0) begin
                  state_q  <= ST_DONE;
                  ready_q  <= 1'b1;
                  dz_q     <= 1'b1;
                  result_q <= {opdata1_i, {DATA_W{1'b1}}};
                end else begin
                  state_q <= ST_DIV;
                  busy_q  <= 1'b1;
                end
              end else begin
                state_q  <= ST_MUL;
                busy_q   <= 1'b1;
                cnt_q    <= '0;
                prod_q   <= '0;
                mcand_q  <= {{DATA_W{1'b0}}, a_mag};
                mplier_q <= b_mag;
              end
            end
          end
          ST_MUL: begin
            prod_q   <= prod_d;
            mcand_q  <= mcand_q << MUL_BITS;
            mplier_q <= mplier_q >> MUL_BITS;
            cnt_q    <= cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(N - 1)) begin
              if (op_is_acc(op_q)) begin
                state_q <= ST_ACC;
              end else begin
                state_q  <= ST_DONE;
                busy_q   <= 1'b0;
                ready_q  <= 1'b1;
                result_q <= mul_res;
              end
            end
          end
          ST_ACC: begin
            state_q  <= ST_DONE;
            busy_q   <= 1'b0;
            ready_q  <= 1'b1;
            result_q <= acc_d;
          end
          ST_DIV: begin
            if (div_last) begin
              state_q  <= ST_DONE;
              busy_q   <= 1'b0;
              ready_q  <= 1'b1;
              result_q <= {rem_fix, quot_fix};
            end
          end
          default: begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign busy_o     = busy_q;
  assign ready_o    = ready_q;
  assign result_o   = result_q;
  assign div_zero_o = dz_q;

endmodule

`default_nettype wire
